// File: rtl/rr_stream_merge_2to1.sv
// Two-input valid/ready stream merger: per-input circular FIFOs feed a registered
// output stage through a 2-request round-robin arbiter; each word is tagged with its source.
module rr_stream_merge_2to1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [1:0]       in_valid;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       req;
  logic [WIDTH-1:0] in_data [2];
  logic [WIDTH-1:0] head    [2];

  logic             gnt;
  logic             load;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic             last_q;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    wptr_q;
    logic [CW-1:0]    cnt_q;

    assign full[g]  = (cnt_q == FullCnt);
    assign empty[g] = (cnt_q == '0);
    // Ready comes from registered occupancy only, so a full FIFO refuses a push
    // even on a cycle in which it is popped.
    assign push[g]  = in_valid[g] && !full[g];
    assign head[g]  = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[g]) wptr_q <= wptr_q + 1'b1;
        if (pop[g])  rptr_q <= rptr_q + 1'b1;
        if (push[g] && !pop[g]) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (pop[g] && !push[g]) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    // Storage needs no reset: the pointers and counter define which entries are live.
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q] <= in_data[g];
    end
  end

  assign in0_ready = !full[0];
  assign in1_ready = !full[1];

  assign req  = ~empty;
  assign load = (!out_valid_q || out_ready) && (req != 2'b00);

  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  assign pop = load ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= head[gnt];
      out_src_q   <= gnt;
      last_q      <= gnt;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_stream_merge_2to1.sv
// Bench for rr_stream_merge_2to1: directed streams with hand-computed expected output
// order pushed into a scoreboard queue, checked by an independent negedge monitor.
module tb_rr_stream_merge_2to1;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] in1_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q [$];
  logic [7:0] s0_q  [$];
  logic [7:0] s1_q  [$];

  logic       stalled = 1'b0;
  logic [8:0] held    = '0;

  rr_stream_merge_2to1 #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in0_data (in0_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .in1_data (in1_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic src, input logic [7:0] data);
    exp_q.push_back({src, data});
  endtask

  // Drives both sources from s0_q/s1_q, honouring in_ready; starts and ends at posedge+1.
  task automatic stream(input bit rnd_ready);
    int guard;
    bit a0;
    bit a1;
    guard = 0;
    while ((s0_q.size() > 0 || s1_q.size() > 0) && guard < 200) begin
      in0_valid = (s0_q.size() > 0);
      in0_data  = in0_valid ? s0_q[0] : '0;
      in1_valid = (s1_q.size() > 0);
      in1_data  = in1_valid ? s1_q[0] : '0;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      @(posedge clk);
      #1;
      if (a0) void'(s0_q.pop_front());
      if (a1) void'(s1_q.pop_front());
      guard++;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout actual=%0d expected=<200 cycles", guard);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  // Scoreboard monitor: compares every accepted word and output stability under stall.
  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {out_src, out_data}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h expected=none", {out_src, out_data});
        end else begin
          check("out_word", {out_src, out_data}, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_src, out_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    in0_valid = 1'b0;
    in0_data  = '0;
    in1_valid = 1'b0;
    in1_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in0_ready", in0_ready, 1);
    check("rst_in1_ready", in1_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Mid-stream reset with both FIFOs partly full and a word parked in the output.
    s0_q.push_back(8'h01); s0_q.push_back(8'h02);
    s1_q.push_back(8'h03); s1_q.push_back(8'h04);
    stream(1'b0);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_in1_cnt_ready", in1_ready, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in0_ready", in0_ready, 1);
    check("mid_rst_in1_ready", in1_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First word after reset: pushed at edge N, visible after edge N+1.
    out_ready = 1'b1;
    expect_word(1'b0, 8'h3C);
    in0_valid = 1'b1;
    in0_data  = 8'h3C;
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    check("lat_no_bypass", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_word", {out_src, out_data}, {1'b0, 8'h3C});
    drain();

    // Idle gap: single word on in1 is valid for exactly one accepted cycle.
    expect_word(1'b1, 8'h5A);
    s1_q.push_back(8'h5A);
    stream(1'b0);
    check("idle_no_bypass", out_valid, 0);
    @(posedge clk);
    #1;
    check("idle_valid", out_valid, 1);
    check("idle_src", out_src, 1);
    @(posedge clk);
    #1;
    check("idle_valid_drop", out_valid, 0);

    // Contention: last=1 so input 0 wins first, then strict alternation.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s0_q.push_back(8'hA0 + 8'(i));
      s1_q.push_back(8'hB0 + 8'(i));
      expect_word(1'b0, 8'hA0 + 8'(i));
      expect_word(1'b1, 8'hB0 + 8'(i));
    end
    stream(1'b0);
    check("cont_stall_word", {out_src, out_data}, {1'b0, 8'hA0});
    drain();

    // Single-source grants still move the pointer; next contention goes to input 0.
    expect_word(1'b1, 8'h11);
    expect_word(1'b1, 8'h22);
    s1_q.push_back(8'h11); s1_q.push_back(8'h22);
    stream(1'b0);
    drain();
    expect_word(1'b0, 8'hC0);
    expect_word(1'b1, 8'hD0);
    s0_q.push_back(8'hC0);
    s1_q.push_back(8'hD0);
    stream(1'b0);
    drain();

    // Backpressure: P0 parks in the output register, both FIFOs fill to DEPTH.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) s0_q.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 4; i++) s1_q.push_back(8'h60 + 8'(i));
    expect_word(1'b0, 8'h50);
    for (int i = 0; i < 4; i++) begin
      expect_word(1'b1, 8'h60 + 8'(i));
      expect_word(1'b0, 8'h51 + 8'(i));
    end
    stream(1'b0);
    check("bp_in0_full", in0_ready, 0);
    check("bp_in1_full", in1_ready, 0);
    check("bp_stall_word", {out_src, out_data}, {1'b0, 8'h50});
    repeat (3) @(posedge clk);
    #1;
    check("bp_in0_still_full", in0_ready, 0);
    check("bp_in1_still_full", in1_ready, 0);
    drain();

    // Wrap-around: 3*DEPTH words through FIFO0 with random output stalls.
    for (int i = 0; i < 3 * D; i++) begin
      s0_q.push_back(8'h70 + 8'(i));
      expect_word(1'b0, 8'h70 + 8'(i));
    end
    stream(1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
